fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 135 +++++++++++++
 tb/tb_fifo_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// Burst reader: pops words from a first-word-fall-through FIFO into a 2-entry skid
// buffer feeding a valid/ready stream. Optional empty-FIFO timeout under FIFO_READER_TIMEOUT_EN.
module fifo_reader #(
  parameter int WIDTH   = 8,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cg,
  input  logic             i_start,
  input  logic [LENW-1:0]  i_len,
  input  logic             i_abort,
  input  logic             i_fifoEmpty,
  input  logic [WIDTH-1:0] i_fifoData,
  output logic             o_fifoPop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [LENW-1:0]  o_count,
  output logic             o_timeout
);

  typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

  state_t           state;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  count_inc;
  logic [1:0]       skid_cnt;
  logic [WIDTH-1:0] skid0;
  logic [WIDTH-1:0] skid1;
  logic             limit;
  logic             last_pop;
  logic             xfer;
  logic             to_hit;

  assign count_inc = o_count + LENW'(1);
  assign limit     = (len_q != '0) && (o_count == len_q);
  assign o_fifoPop = (state == DRAIN) && !i_fifoEmpty && (skid_cnt < 2'd2) &&
                     i_cg && !i_abort && !limit;
  assign last_pop  = o_fifoPop && (len_q != '0) && (count_inc == len_q);
  assign xfer      = o_valid && i_ready && i_cg;

  // skid0 always holds the oldest entry, so the stream outputs are plain register reads.
  assign o_valid = (skid_cnt != 2'd0);
  assign o_data  = skid0;
  assign o_busy  = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= IDLE;
      len_q    <= '0;
      o_count  <= '0;
      o_done   <= 1'b0;
      skid_cnt <= 2'd0;
      // NOTE: the skid entries are reset too, because skid0 is o_data and must read 0 in reset.
      skid0    <= '0;
      skid1    <= '0;
    end else begin
      // NOTE: o_done defaults low every edge so it is a single-cycle pulse even if i_cg drops.
      o_done <= 1'b0;
      if (i_cg) begin
        case (state)
          IDLE: begin
            if (i_start) begin
              state   <= DRAIN;
              len_q   <= i_len;
              o_count <= '0;
            end
          end
          DRAIN: begin
            if (o_fifoPop) o_count <= count_inc;
            if (i_abort || last_pop || to_hit) state <= FLUSH;
          end
          FLUSH: begin
            if (skid_cnt == 2'd0) begin
              state  <= IDLE;
              o_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase

        if (o_fifoPop && !xfer) begin
          if (skid_cnt == 2'd0) skid0 <= i_fifoData;
          else                  skid1 <= i_fifoData;
          skid_cnt <= skid_cnt + 2'd1;
        end else if (!o_fifoPop && xfer) begin
          skid0    <= skid1;
          skid_cnt <= skid_cnt - 2'd1;
        end else if (o_fifoPop && xfer) begin
          // Push and pop together: count unchanged, new word queues behind the survivor.
          if (skid_cnt == 2'd1) begin
            skid0 <= i_fifoData;
          end else begin
            skid0 <= skid1;
            skid1 <= i_fifoData;
          end
        end
      end
    end
  end

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] empty_cnt;

  assign to_hit = (state == DRAIN) && i_fifoEmpty && !i_abort &&
                  (empty_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      empty_cnt <= '0;
      o_timeout <= 1'b0;
    end else if (i_cg) begin
      if (state == IDLE && i_start) begin
        empty_cnt <= '0;
        o_timeout <= 1'b0;
      end else if (state == DRAIN) begin
        empty_cnt <= i_fifoEmpty ? empty_cnt + TW'(1) : '0;
        if (to_hit) o_timeout <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;

  assign to_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a queue models the upstream FWFT FIFO, a table of
// bursts drives the main checks, hand sequences cover backpressure, gating, reset and timeout.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       i_rst, i_cg, i_start, i_abort, i_fifoEmpty, i_ready;
  logic [7:0] i_len, i_fifoData;
  logic       o_fifoPop, o_valid, o_busy, o_done, o_timeout;
  logic [7:0] o_data, o_count;

  fifo_reader #(.WIDTH(8), .LENW(8), .TIMEOUT(16)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_cg(i_cg), .i_start(i_start), .i_len(i_len),
    .i_abort(i_abort), .i_fifoEmpty(i_fifoEmpty), .i_fifoData(i_fifoData),
    .o_fifoPop(o_fifoPop), .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_timeout(o_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] len;
    int         words;
    int         abort_after;
    logic [7:0] exp_count;
    int         exp_out;
    int         exp_left;
  } vec_t;

  int         n_total = 0;
  int         n_pass  = 0;
  logic [7:0] up_q[$];
  logic [7:0] out_q[$];
  int         n_pops, n_done;
  logic       s_pop, s_valid, s_done, s_busy;
  logic [7:0] s_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] word(input int k, input int i);
    return 8'((k * 37 + i * 5 + 3) & 255);
  endfunction

  task automatic drive_fifo();
    i_fifoEmpty = (up_q.size() == 0);
    i_fifoData  = (up_q.size() != 0) ? up_q[0] : 8'h00;
  endtask

  task automatic load(input int k, input int n);
    up_q.delete();
    out_q.delete();
    for (int i = 0; i < n; i++) up_q.push_back(word(k, i));
    n_pops = 0;
    n_done = 0;
    drive_fifo();
  endtask

  // Samples outputs at the falling edge, then advances past the rising edge and updates the FIFO model.
  task automatic step();
    @(negedge clk);
    s_pop   = o_fifoPop;
    s_valid = o_valid;
    s_data  = o_data;
    s_done  = o_done;
    s_busy  = o_busy;
    if (s_pop) n_pops++;
    if (s_done) n_done++;
    if (o_valid && i_ready && i_cg) out_q.push_back(o_data);
    @(posedge clk);
    #1;
    if (s_pop && up_q.size() != 0) up_q.delete(0);
    drive_fifo();
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 0;
    while (n_done == 0 && cyc < budget) begin
      step();
      cyc++;
    end
  endtask

  task automatic start(input logic [7:0] len);
    i_len   = len;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  task automatic abort_and_finish(input string name);
    int cyc;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    wait_done(50, cyc);
    check({name, " done seen"}, 32'(n_done != 0), 32'd1);
  endtask

  function automatic logic [31:0] order_ok(input int k, input int n);
    if (out_q.size() != n) return 32'd0;
    for (int i = 0; i < n; i++) if (out_q[i] !== word(k, i)) return 32'd0;
    return 32'd1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[6];
    logic [8:0] pop_tr, val_tr, done_tr, busy_tr;
    logic [7:0] d_tr[9];
    logic [7:0] ref_count, ref_data;
    logic       ref_valid, frozen_ok;
    int         cyc, pops_before;

    vecs[0] = '{len: 8'd4,   words: 4,   abort_after: 0,   exp_count: 8'd4,   exp_out: 4,   exp_left: 0};
    vecs[1] = '{len: 8'd2,   words: 5,   abort_after: 0,   exp_count: 8'd2,   exp_out: 2,   exp_left: 3};
    vecs[2] = '{len: 8'd1,   words: 3,   abort_after: 0,   exp_count: 8'd1,   exp_out: 1,   exp_left: 2};
    vecs[3] = '{len: 8'd0,   words: 6,   abort_after: 3,   exp_count: 8'd3,   exp_out: 3,   exp_left: 3};
    vecs[4] = '{len: 8'd255, words: 255, abort_after: 0,   exp_count: 8'd255, exp_out: 255, exp_left: 0};
    vecs[5] = '{len: 8'd0,   words: 258, abort_after: 258, exp_count: 8'd2,   exp_out: 258, exp_left: 0};

    i_rst = 1'b0; i_cg = 1'b1; i_start = 1'b0; i_len = '0; i_abort = 1'b0; i_ready = 1'b1;
    load(0, 0);
    #12;
    check("reset outputs", {o_valid, o_fifoPop, o_busy, o_done, o_timeout}, 32'd0);
    check("reset data/count", {o_data, o_count}, 32'd0);
    @(posedge clk);
    #1;
    i_rst = 1'b1;

    // Four words with len=4: exact cycle trace.
    up_q.delete();
    up_q.push_back(8'hA1); up_q.push_back(8'hB2); up_q.push_back(8'hC3); up_q.push_back(8'hD4);
    n_pops = 0; n_done = 0; drive_fifo();
    i_len = 8'd4; i_start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      i_start   = 1'b0;
      pop_tr[i] = s_pop; val_tr[i] = s_valid; done_tr[i] = s_done; busy_tr[i] = s_busy;
      d_tr[i]   = s_data;
    end
    check("abcd pop trace", 32'(pop_tr), 32'(9'b000011110));
    check("abcd valid trace", 32'(val_tr), 32'(9'b000111100));
    check("abcd data order", {d_tr[2], d_tr[3], d_tr[4], d_tr[5]}, 32'hA1B2C3D4);
    check("abcd done trace", 32'(done_tr), 32'(9'b010000000));
    check("abcd busy trace", 32'(busy_tr), 32'(9'b001111110));
    check("abcd count", 32'(o_count), 32'd4);

    // Table of bursts.
    for (int k = 0; k < 6; k++) begin
      logic aborted;
      load(k + 1, vecs[k].words);
      i_ready = 1'b1;
      aborted = 1'b0;
      start(vecs[k].len);
      cyc = 0;
      while (n_done == 0 && cyc < 2000) begin
        i_abort = vecs[k].abort_after != 0 && !aborted && n_pops == vecs[k].abort_after;
        if (i_abort) aborted = 1'b1;
        step();
        cyc++;
      end
      i_abort = 1'b0;
      check($sformatf("vec%0d done seen", k), 32'(n_done != 0), 32'd1);
      step();
      step();
      check($sformatf("vec%0d done pulses", k), 32'(n_done), 32'd1);
      check($sformatf("vec%0d count", k), 32'(o_count), 32'(vecs[k].exp_count));
      check($sformatf("vec%0d words out", k), 32'(out_q.size()), 32'(vecs[k].exp_out));
      check($sformatf("vec%0d data order", k), order_ok(k + 1, vecs[k].exp_out), 32'd1);
      check($sformatf("vec%0d fifo left", k), 32'(up_q.size()), 32'(vecs[k].exp_left));
      check($sformatf("vec%0d idle", k), 32'(o_busy), 32'd0);
    end

    // Backpressure: only the skid fills, then words drain in order.
    load(10, 5);
    i_ready = 1'b0;
    start(8'd0);
    repeat (6) step();
    check("bp pops while stalled", 32'(n_pops), 32'd2);
    check("bp pop held low", 32'(s_pop), 32'd0);
    check("bp fifo left", 32'(up_q.size()), 32'd3);
    i_ready = 1'b1;
    cyc = 0;
    while (out_q.size() < 5 && cyc < 50) begin
      step();
      cyc++;
    end
    check("bp data order", order_ok(10, 5), 32'd1);
    abort_and_finish("bp");
    check("bp count", 32'(o_count), 32'd5);

    // Clock gate held low mid-burst.
    load(11, 8);
    start(8'd0);
    repeat (3) step();
    i_cg = 1'b0;
    ref_count = o_count; ref_data = o_data; ref_valid = o_valid;
    pops_before = n_pops;
    frozen_ok = 1'b1;
    repeat (5) begin
      step();
      if (o_count !== ref_count || o_data !== ref_data || o_valid !== ref_valid || s_done)
        frozen_ok = 1'b0;
    end
    check("cg frozen", 32'(frozen_ok), 32'd1);
    check("cg no pops", 32'(n_pops - pops_before), 32'd0);
    i_cg = 1'b1;
    cyc = 0;
    while (out_q.size() < 8 && cyc < 50) begin
      step();
      cyc++;
    end
    check("cg data order", order_ok(11, 8), 32'd1);
    abort_and_finish("cg");
    check("cg count", 32'(o_count), 32'd8);

    // len=1 with data already waiting: done no earlier than 3 cycles after start.
    load(12, 2);
    start(8'd1);
    wait_done(20, cyc);
    check("len1 latency >= 3", 32'(cyc >= 3), 32'd1);
    check("len1 data", order_ok(12, 1), 32'd1);

    // Asynchronous reset with a full skid.
    load(13, 5);
    i_ready = 1'b0;
    start(8'd0);
    repeat (3) step();
    check("rst skid full", 32'(o_valid), 32'd1);
    #2;
    i_rst = 1'b0;
    #1;
    check("rst async valid/busy", {o_valid, o_busy}, 32'd0);
    check("rst async count/data", {o_count, o_data}, 32'd0);
    step();
    i_rst = 1'b1;
    i_ready = 1'b1;
    load(0, 0);

`ifdef FIFO_READER_TIMEOUT_EN
    start(8'd0);
    wait_done(40, cyc);
    check("timeout latency", 32'(cyc), 32'd18);
    check("timeout flag", 32'(o_timeout), 32'd1);
    load(14, 1);
    start(8'd0);
    check("timeout cleared by start", 32'(o_timeout), 32'd0);
    abort_and_finish("timeout");
`else
    start(8'd0);
    repeat (20) step();
    check("no timeout busy", 32'(s_busy), 32'd1);
    check("no timeout flag", 32'(o_timeout), 32'd0);
    abort_and_finish("no timeout");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
